alt_vipcti121_is2vid_read_buffer: RTL and testbench
===================================================

Name: alt_vipcti121_IS2Vid_read_buffer

Overview:
Unpacking read buffer on the output side of the clocked-video path, the counterpart of the Vid2IS write buffer. It pops parallel words (NUMBER_OF_COLOUR_PLANES x BPS) from a show-ahead FIFO and presents them to the video formatter. In HD mode each word is presented whole. In SD convert mode each word is serialised into one BPS-wide sample per cycle, plane 0 first. It also carries the control-packet flag and supports a flush that discards a partially consumed word.

Parameters:
DATA_WIDTH, 20, width of FIFO word and data_out; equals NUMBER_OF_COLOUR_PLANES*BPS
NUMBER_OF_COLOUR_PLANES, 2, samples per packed word
BPS, 10, bits per sample

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
convert  in  1  SD only: 1 = serialise word into samples, 0 = ancillary/raw (plane 0 only)
hd_sdn  in  1  1 = HD (whole word out), 0 = SD
flush  in  1  discard buffered word and remaining samples
empty_in  in  1  FIFO empty; data_in/packet_in valid when 0
data_in  in  DATA_WIDTH  FIFO head word
packet_in  in  1  FIFO head is control-packet data
rdreq_out  out  1  FIFO pop (combinational)
rdreq_in  in  1  formatter requests next sample/word
valid_out  out  1  data_out/packet_out updated this cycle
data_out  out  DATA_WIDTH  sample (low BPS bits, upper zero) or whole word
packet_out  out  1  sample belongs to control packet

Behaviour:
- State: buf_data (DATA_WIDTH), count (0..NUMBER_OF_COLOUR_PLANES, samples remaining), sel (plane index), buf_packet, mode_q (latched {hd_sdn, convert}).
- Reset: count=0, sel=0, buf_data=0, buf_packet=0, mode_q=0, valid_out=0, data_out=0, packet_out=0.
- rdreq_out = !empty_in && !flush && (count==0 || (rdreq_in && count==1)).
- Load, on rdreq_out:
  - buf_data<=data_in, buf_packet<=packet_in, sel<=0.
  - mode_q<={hd_sdn,convert}.
  - count<=NUMBER_OF_COLOUR_PLANES if (!hd_sdn && convert), else 1.
- Mode inputs are sampled only at load. Changing them mid-word does not affect the buffered word.
- Serve, on rdreq_in && count!=0 && !flush; registered, 1-cycle latency:
  - valid_out<=1, packet_out<=buf_packet.
  - HD: data_out<=buf_data.
  - SD convert: data_out<={zeros, plane[sel]}; sel<=sel+1.
  - SD !convert: data_out<={zeros, plane0}.
  - count<=count-1, unless a simultaneous load applies, in which case the load values win.
- Otherwise: valid_out<=0; data_out and packet_out hold.
- rdreq_in with count==0: ignored, no output. The formatter re-requests. This is a one-cycle bubble on the first word only.
- Steady state: continuous rdreq_in with a non-empty FIFO gives one sample (SD) or one word (HD) per cycle with no bubbles. The reload overlaps consumption of the last sample.
- flush has priority over everything:
  - count<=0, sel<=0, buf_packet<=0, valid_out<=0.
  - rdreq_out=0 in that cycle.
- FIFO empty when count reaches 0: no pop, no output until !empty_in. rdreq_out is never asserted while empty_in=1.
- Reset mid-word: the buffered word is lost. It is not re-popped.

Decomposition:
- No shared package needed. Parameters are local.
- Plane extraction (sel -> BPS slice mux) may be a small function inside the module. No sub-module.

Test Plan:
1. SD convert, FIFO word 0xAAD55 (plane1=0x2AB, plane0=0x155), rdreq_in held -> rdreq_out pulses once at load; valid_out on two consecutive cycles with data_out 0x00155 then 0x002AB.
2. HD, three words 0x11111/0x22222/0x33333, rdreq_in held -> after a one-cycle start bubble, data_out 0x11111, 0x22222, 0x33333 on consecutive cycles, with one pop per cycle.
3. SD !convert, word 0xAAD55 with packet_in=1 -> single output 0x00155, packet_out=1, count returns to 0 after one serve.
4. SD convert, flush asserted after the first sample of 0xAAD55, with rdreq_in high -> no output that cycle; next output is plane0 of the following FIFO word; 0x002AB is never emitted.
5. FIFO empties mid-stream (empty_in=1 for 3 cycles) -> valid_out low for those cycles, rdreq_out stays 0, and the stream resumes cleanly.
6. rst asserted while count=1 -> all outputs 0 immediately (asynchronous); after release, the first request returns the next FIFO word.

Source files
------------

// File: rtl/alt_vipcti121_is2vid_read_buffer.sv
// Output-side read buffer: pops packed words from a show-ahead FIFO and presents
// them whole (HD) or serialised one BPS sample per cycle, plane 0 first (SD convert).
module alt_vipcti121_is2vid_read_buffer #(
  parameter int unsigned DATA_WIDTH              = 20,
  parameter int unsigned NUMBER_OF_COLOUR_PLANES = 2,
  parameter int unsigned BPS                     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  convert,
  input  logic                  hd_sdn,
  input  logic                  flush,
  input  logic                  empty_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  packet_in,
  output logic                  rdreq_out,
  input  logic                  rdreq_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  packet_out
);

  localparam int unsigned NP   = NUMBER_OF_COLOUR_PLANES;
  localparam int unsigned CntW = $clog2(NP + 1);
  localparam int unsigned SelW = (NP > 1) ? $clog2(NP) : 1;

  function automatic logic [BPS-1:0] f_plane(input logic [DATA_WIDTH-1:0] d,
                                             input logic [SelW-1:0]       s);
    return d[s*BPS +: BPS];
  endfunction

  logic [DATA_WIDTH-1:0] r_buf_data;
  logic [CntW-1:0]       r_count;
  logic [SelW-1:0]       r_sel;
  logic                  r_buf_packet;
  logic                  r_mode_hd;
  logic                  r_mode_cv;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_packet_out;

  logic w_load;
  logic w_serve;

  // Reload overlaps the serve of the last sample so a held request never bubbles.
  assign w_load  = !empty_in && !flush &&
                   ((r_count == '0) || (rdreq_in && (r_count == CntW'(1))));
  assign w_serve = rdreq_in && (r_count != '0) && !flush;

  assign rdreq_out  = w_load;
  assign valid_out  = r_valid;
  assign data_out   = r_data_out;
  assign packet_out = r_packet_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_data   <= '0;
      r_count      <= '0;
      r_sel        <= '0;
      r_buf_packet <= 1'b0;
      r_mode_hd    <= 1'b0;
      r_mode_cv    <= 1'b0;
      r_valid      <= 1'b0;
      r_data_out   <= '0;
      r_packet_out <= 1'b0;
    end else if (flush) begin
      r_count      <= '0;
      r_sel        <= '0;
      r_buf_packet <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      if (w_serve) begin
        r_valid      <= 1'b1;
        r_packet_out <= r_buf_packet;
        r_count      <= r_count - CntW'(1);
        if (r_mode_hd) begin
          r_data_out <= r_buf_data;
        end else if (r_mode_cv) begin
          r_data_out <= DATA_WIDTH'(f_plane(r_buf_data, r_sel));
          r_sel      <= r_sel + SelW'(1);
        end else begin
          r_data_out <= DATA_WIDTH'(f_plane(r_buf_data, '0));
        end
      end else begin
        r_valid <= 1'b0;
      end
      // Mode is captured with the word so mid-word mode changes cannot corrupt it.
      if (w_load) begin
        r_buf_data   <= data_in;
        r_buf_packet <= packet_in;
        r_sel        <= '0;
        r_mode_hd    <= hd_sdn;
        r_mode_cv    <= convert;
        r_count      <= (!hd_sdn && convert) ? CntW'(NP) : CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alt_vipcti121_is2vid_read_buffer.sv
// Bench for the IS2Vid read buffer: directed scenarios then random traffic, checked
// against a queue-of-pending-samples reference model.
module tb_alt_vipcti121_is2vid_read_buffer;

  localparam int DW  = 20;
  localparam int NP  = 2;
  localparam int BPS = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          convert, hd_sdn, flush, empty_in, packet_in, rdreq_in;
  logic [DW-1:0] data_in;
  logic          rdreq_out, valid_out, packet_out;
  logic [DW-1:0] data_out;

  alt_vipcti121_is2vid_read_buffer #(
    .DATA_WIDTH              (DW),
    .NUMBER_OF_COLOUR_PLANES (NP),
    .BPS                     (BPS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .convert    (convert),
    .hd_sdn     (hd_sdn),
    .flush      (flush),
    .empty_in   (empty_in),
    .data_in    (data_in),
    .packet_in  (packet_in),
    .rdreq_out  (rdreq_out),
    .rdreq_in   (rdreq_in),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .packet_out (packet_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  int n_valid  = 0;
  logic stall  = 1'b0;

  logic [DW:0] fq[$];  // test-side FIFO, bit DW = packet flag
  logic [DW:0] pq[$];  // model: samples still to be emitted from the buffered word
  logic          m_valid, m_pkt;
  logic [DW-1:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_head();
    empty_in = stall || (fq.size() == 0);
    if (fq.size() != 0) begin
      data_in   = fq[0][DW-1:0];
      packet_in = fq[0][DW];
    end else begin
      data_in   = DW'($urandom);
      packet_in = 1'($urandom);
    end
  endtask

  // One clock: check the combinational pop, advance the model, check registered outputs.
  task automatic step();
    logic        exp_rd, serve;
    int          n;
    logic [DW:0] w;
    drive_head();
    #2;
    n      = pq.size();
    exp_rd = !empty_in && !flush && (n == 0 || (rdreq_in && n == 1));
    serve  = rdreq_in && n != 0 && !flush;
    chk("rdreq_out", 32'(rdreq_out), 32'(exp_rd));
    if (flush) begin
      pq.delete();
      m_valid = 1'b0;
    end else begin
      if (serve) begin
        m_valid = 1'b1;
        m_data  = pq[0][DW-1:0];
        m_pkt   = pq[0][DW];
        void'(pq.pop_front());
      end else begin
        m_valid = 1'b0;
      end
      if (exp_rd) begin
        w = fq.pop_front();
        n_pops++;
        pq.delete();
        if (hd_sdn) pq.push_back(w);
        else if (convert)
          for (int i = 0; i < NP; i++)
            pq.push_back({w[DW], DW'((w[DW-1:0] >> (i*BPS)) & ((1 << BPS) - 1))});
        else pq.push_back({w[DW], DW'(w[BPS-1:0])});
      end
    end
    @(posedge clk);
    #1;
    if (valid_out === 1'b1) n_valid++;
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("packet_out", 32'(packet_out), 32'(m_pkt));
  endtask

  task automatic set_in(input logic hd, input logic cv, input logic rq, input logic fl);
    hd_sdn = hd; convert = cv; rdreq_in = rq; flush = fl;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 1, 0, 0);
    drive_head();
    m_valid = 0; m_data = '0; m_pkt = 0;
    #12;
    chk("reset_valid", 32'(valid_out), 32'h0);
    chk("reset_data", 32'(data_out), 32'h0);
    chk("reset_packet", 32'(packet_out), 32'h0);
    chk("reset_rdreq", 32'(rdreq_out), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: SD convert, one word serialised plane 0 first
    n_pops = 0; n_valid = 0;
    fq.push_back({1'b0, 20'hAAD55});
    set_in(0, 1, 1, 0);
    repeat (4) step();
    chk("t1_pops", 32'(n_pops), 32'd1);
    chk("t1_valids", 32'(n_valid), 32'd2);

    // 2: HD, three words back to back
    n_pops = 0; n_valid = 0;
    fq.push_back({1'b0, 20'h11111});
    fq.push_back({1'b0, 20'h22222});
    fq.push_back({1'b0, 20'h33333});
    set_in(1, 0, 1, 0);
    step();
    step(); chk("t2_w0", 32'(data_out), 32'h11111);
    step(); chk("t2_w1", 32'(data_out), 32'h22222);
    step(); chk("t2_w2", 32'(data_out), 32'h33333);
    chk("t2_pops", 32'(n_pops), 32'd3);
    step();

    // 3: SD raw, packet flag carried, single sample
    fq.push_back({1'b1, 20'hAAD55});
    set_in(0, 0, 1, 0);
    step(); step();
    chk("t3_data", 32'(data_out), 32'h00155);
    chk("t3_pkt", 32'(packet_out), 32'h1);
    step();
    chk("t3_done", 32'(pq.size()), 32'd0);

    // 4: flush after first sample drops plane 1
    fq.push_back({1'b0, 20'hAAD55});
    set_in(0, 1, 1, 0);
    step(); step();
    chk("t4_first", 32'(data_out), 32'h00155);
    fq.push_back({1'b0, 20'h0F0C3});
    flush = 1'b1; step();
    flush = 1'b0; step(); step();
    chk("t4_next", 32'(data_out), 32'h000C3);
    step(); step();

    // 5: FIFO runs dry for three cycles mid-stream
    for (int i = 0; i < 3; i++) fq.push_back({1'b0, 20'(32'h12345 * (i + 1))});
    set_in(0, 1, 1, 0);
    step(); step(); step();
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    repeat (6) step();

    // 6: asynchronous reset while one sample remains
    fq.push_back({1'b1, 20'hAAD55});
    fq.push_back({1'b0, 20'h54321});
    set_in(0, 1, 1, 0);
    stall = 1'b1; step(); stall = 1'b0;
    step(); step();
    rdreq_in = 1'b0; stall = 1'b1; step();
    chk("t6_pending", 32'(pq.size()), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(valid_out), 32'h0);
    chk("t6_rst_data", 32'(data_out), 32'h0);
    chk("t6_rst_pkt", 32'(packet_out), 32'h0);
    pq.delete(); m_valid = 0; m_data = '0; m_pkt = 0;
    @(posedge clk); #1;
    rst = 1'b0; stall = 1'b0;
    rdreq_in = 1'b1;
    step(); step();
    chk("t6_after", 32'(data_out), 32'h00321);
    step(); step();

    // Random traffic
    for (int c = 0; c < 500; c++) begin
      if (fq.size() < 4 && $urandom_range(0, 1) == 1)
        fq.push_back({1'($urandom), DW'($urandom)});
      rdreq_in = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      stall    = ($urandom_range(0, 7) == 0);
      hd_sdn   = 1'($urandom);
      convert  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
